// File: rtl/alarm_pkg.sv
// Shared state encodings and default parameter values for the alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam int         DEF_CLK_HZ    = 50_000_000;
  localparam int         DEF_EXIT_S    = 10;
  localparam int         DEF_ENTRY_S   = 10;
  localparam logic [3:0] DEF_CODE      = 4'hA;
  localparam int         DEF_MAX_FAILS = 3;

endpackage

// File: rtl/tick_gen.sv
// One-cycle tick every CLK_HZ clocks; restart realigns the period to the current cycle.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int             CW   = $clog2(CLK_HZ + 1);
  localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // restart wins over wrap so a new state always gets a full first second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Intrusion alarm: keypad-code arm/disarm, exit and entry delays, wrong-code lockout.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int         CLK_HZ    = DEF_CLK_HZ,
  parameter int         EXIT_S    = DEF_EXIT_S,
  parameter int         ENTRY_S   = DEF_ENTRY_S,
  parameter logic [3:0] CODE      = DEF_CODE,
  parameter int         MAX_FAILS = DEF_MAX_FAILS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sensor,
  input  logic [3:0] code_in,
  input  logic       enter_n,
  output logic       aux,
  output logic       armed,
  output logic [2:0] state,
  output logic [5:0] secs_left,
  output logic [2:0] fail_cnt
);

  logic [3:0] r_sens_s1, r_sens_s2;
  logic       r_en_s1, r_en_s2, r_en_d;
  logic [2:0] r_state;
  logic [5:0] r_secs;
  logic [2:0] r_fail;

  logic [2:0] w_state_nxt;
  logic [5:0] w_secs_nxt;
  logic [2:0] w_fail_nxt;
  logic [2:0] w_fail_inc;
  logic       w_enter, w_good, w_bad, w_sens_any, w_tick, w_restart;

  // Synchronizers idle to "button released" and "all contacts closed"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sens_s1 <= '0;
      r_sens_s2 <= '0;
      r_en_s1   <= 1'b1;
      r_en_s2   <= 1'b1;
      r_en_d    <= 1'b1;
    end else begin
      r_sens_s1 <= sensor;
      r_sens_s2 <= r_sens_s1;
      r_en_s1   <= enter_n;
      r_en_s2   <= r_en_s1;
      r_en_d    <= r_en_s2;
    end
  end

  assign w_enter    = r_en_d & ~r_en_s2;
  assign w_good     = w_enter && (code_in == CODE);
  assign w_bad      = w_enter && (code_in != CODE);
  assign w_sens_any = |r_sens_s2;
  assign w_fail_inc = (r_fail == 3'd7) ? 3'd7 : r_fail + 3'd1;
  assign w_restart  = (w_state_nxt != r_state);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // Priority inside each state: good code, then lockout, then sensor/timeout
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = r_secs;
    w_fail_nxt  = r_fail;
    case (r_state)
      S_DISARMED: begin
        if (w_good) begin
          w_state_nxt = S_ARMING;
          w_secs_nxt  = 6'(EXIT_S);
        end
      end
      S_ARMING: begin
        if (w_good) begin
          w_state_nxt = S_DISARMED;
        end else if (w_tick) begin
          if (r_secs == 6'd1) begin
            w_state_nxt = S_ARMED;
            w_secs_nxt  = 6'd0;
          end else begin
            w_secs_nxt = r_secs - 6'd1;
          end
        end
      end
      S_ARMED, S_ENTRY, S_ALARM: begin
        if (w_good) begin
          w_state_nxt = S_DISARMED;
        end else begin
          if (w_bad) w_fail_nxt = w_fail_inc;
          if (w_bad && (w_fail_inc >= 3'(MAX_FAILS))) begin
            w_state_nxt = S_ALARM;
            w_secs_nxt  = 6'd0;
          end else if ((r_state == S_ARMED) && w_sens_any) begin
            w_state_nxt = S_ENTRY;
            w_secs_nxt  = 6'(ENTRY_S);
          end else if ((r_state == S_ENTRY) && w_tick) begin
            if (r_secs == 6'd1) begin
              w_state_nxt = S_ALARM;
              w_secs_nxt  = 6'd0;
            end else begin
              w_secs_nxt = r_secs - 6'd1;
            end
          end
        end
      end
      default: w_state_nxt = S_DISARMED;
    endcase
    if (w_state_nxt == S_DISARMED) begin
      w_secs_nxt = 6'd0;
      w_fail_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DISARMED;
      r_secs  <= 6'd0;
      r_fail  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_secs  <= w_secs_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  assign state     = r_state;
  assign aux       = (r_state == S_ALARM);
  assign armed     = (r_state == S_ARMING) || (r_state == S_ARMED) || (r_state == S_ENTRY);
  assign secs_left = r_secs;
  assign fail_cnt  = r_fail;

endmodule
